if_fetch_ctrl: RTL and testbench

Fetch-stage sequencer for the five-stage MIPS pipeline. It decides each cycle which next-PC source feeds the PC register, and whether the PC and F/D register advance, hold or flush. It arbitrates between hazard stalls, D-stage control transfers (branch/j/jr/eret) and CP0 exception entry. It tracks delay-slot status for the fetched instruction, which the F-stage exception logic consumes.

---
 rtl/if_fetch_ctrl_if.sv | 40 ++++
 rtl/if_fetch_ctrl.sv | 140 ++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/if_fetch_ctrl_if.sv
// Fetch-control bundle: D/M-stage requests in, next-PC select and F/D control out.
// Optional stall_cnt field present only when IF_CTRL_STALL_CNT_EN is defined.
interface if_fetch_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic       stall_req;
  logic       md_busy;
  logic       br_taken;
  logic       jump;
  logic       jr;
  logic       eret;
  logic       int_req;
  logic [2:0] pc_sel;
  logic       pc_en;
  logic       exc_entry;
  logic       flush_fd;
  logic       stall_fd;
  logic       delay;
`ifdef IF_CTRL_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
`endif

  // Requester side (hazard unit, decode, CP0).
  modport master (
    output stall_req, md_busy, br_taken, jump, jr, eret, int_req,
`ifdef IF_CTRL_STALL_CNT_EN
    input  stall_cnt,
`endif
    input  pc_sel, pc_en, exc_entry, flush_fd, stall_fd, delay
  );

  // Sequencer side.
  modport slave (
    input  stall_req, md_busy, br_taken, jump, jr, eret, int_req,
`ifdef IF_CTRL_STALL_CNT_EN
    output stall_cnt,
`endif
    output pc_sel, pc_en, exc_entry, flush_fd, stall_fd, delay
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencer: chooses the next-PC source and advances, holds or flushes
// the PC and F/D register. Arbitrates hazard stalls, D-stage control transfers and
// CP0 exception entry, and tracks delay-slot status of the fetched instruction.
// Optional feature: define IF_CTRL_STALL_CNT_EN to add a saturating stall counter.
module if_fetch_ctrl #(
  parameter int unsigned EXC_BUBBLES = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  if_fetch_ctrl_if.slave fc
);

  typedef enum logic [1:0] {StRun, StExc, StEret} state_e;

  localparam logic [2:0] PcPlus4  = 3'd0;
  localparam logic [2:0] PcBranch = 3'd1;
  localparam logic [2:0] PcJump   = 3'd2;
  localparam logic [2:0] PcReg    = 3'd3;
  localparam logic [2:0] PcEpc    = 3'd4;
  localparam logic [2:0] BubInit  = 3'(EXC_BUBBLES);

  state_e     state_q, state_d;
  logic [2:0] bub_q, bub_d;
  logic       delay_q, delay_d;

  logic [2:0] pc_sel;
  logic       pc_en;
  logic       exc_entry;
  logic       flush_fd;
  logic       stall_fd;
  logic       take_ctrl;
  logic       stall;

  assign stall = fc.stall_req | fc.md_busy;

  // Next-state and per-cycle fetch control.
  always_comb begin
    pc_sel    = PcPlus4;
    pc_en     = 1'b1;
    exc_entry = 1'b0;
    flush_fd  = 1'b0;
    stall_fd  = 1'b0;
    take_ctrl = 1'b0;
    state_d   = state_q;
    bub_d     = bub_q;
    unique case (state_q)
      StRun: begin
        if (fc.int_req) begin
          exc_entry = 1'b1;
          flush_fd  = 1'b1;
          state_d   = StExc;
          bub_d     = BubInit;
        end else if (stall) begin
          pc_en    = 1'b0;
          stall_fd = 1'b1;
        end else if (fc.eret) begin
          // eret has no delay slot: the wrong-path fetch is dropped.
          pc_sel   = PcEpc;
          flush_fd = 1'b1;
          state_d  = StEret;
        end else if (fc.br_taken) begin
          pc_sel    = PcBranch;
          take_ctrl = 1'b1;
        end else if (fc.jump) begin
          pc_sel    = PcJump;
          take_ctrl = 1'b1;
        end else if (fc.jr) begin
          pc_sel    = PcReg;
          take_ctrl = 1'b1;
        end
      end
      StExc: begin
        // int_req ignored here: CP0 holds EXL until the handler runs.
        pc_en    = 1'b0;
        flush_fd = 1'b1;
        bub_d    = bub_q - 3'd1;
        if (bub_q <= 3'd1) begin
          state_d = StRun;
          bub_d   = 3'd0;
        end
      end
      StEret: begin
        state_d = StRun;
        if (fc.int_req) begin
          exc_entry = 1'b1;
          flush_fd  = 1'b1;
          state_d   = StExc;
          bub_d     = BubInit;
        end
      end
      default: begin
        state_d = StRun;
        bub_d   = 3'd0;
      end
    endcase
  end

  // Delay-slot flag follows the fetch that is accepted; held while PC is frozen.
  always_comb begin
    delay_d = delay_q;
    if (pc_en) delay_d = take_ctrl;
  end

  // State, bubble counter and delay-slot registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StRun;
      bub_q   <= 3'd0;
      delay_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
      delay_q <= delay_d;
    end
  end

  assign fc.pc_sel    = pc_sel;
  assign fc.pc_en     = pc_en;
  assign fc.exc_entry = exc_entry;
  assign fc.flush_fd  = flush_fd;
  assign fc.stall_fd  = stall_fd;
  assign fc.delay     = delay_q;

`ifdef IF_CTRL_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of effective stall cycles in RUN.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else if (stall_fd && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign fc.stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with EXC_BUBBLES=2.
module tb_if_fetch_ctrl;

  logic Clk;
  logic Reset;
  int   n_cmp;
  int   n_err;

  if_fetch_ctrl_if #(.CNT_W(16)) fc_if ();

  if_fetch_ctrl #(
    .EXC_BUBBLES(2),
    .CNT_W      (16)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .fc   (fc_if)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled mid-low-phase.
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic clr_in();
    fc_if.stall_req = 1'b0;
    fc_if.md_busy   = 1'b0;
    fc_if.br_taken  = 1'b0;
    fc_if.jump      = 1'b0;
    fc_if.jr        = 1'b0;
    fc_if.eret      = 1'b0;
    fc_if.int_req   = 1'b0;
  endtask

  // Compact check of all combinational outputs plus delay.
  task automatic chk_out(input string tag, input logic [2:0] sel, input logic en,
                         input logic exc, input logic fl, input logic st, input logic dl);
    #1;
    check({tag, ".pc_sel"},    32'(fc_if.pc_sel),    32'(sel));
    check({tag, ".pc_en"},     32'(fc_if.pc_en),     32'(en));
    check({tag, ".exc_entry"}, 32'(fc_if.exc_entry), 32'(exc));
    check({tag, ".flush_fd"},  32'(fc_if.flush_fd),  32'(fl));
    check({tag, ".stall_fd"},  32'(fc_if.stall_fd),  32'(st));
    check({tag, ".delay"},     32'(fc_if.delay),     32'(dl));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clr_in();
    Reset = 1'b0;
    @(negedge Clk);
    chk_out("reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef IF_CTRL_STALL_CNT_EN
    check("reset.stall_cnt", 32'(fc_if.stall_cnt), 32'd0);
`endif
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("idle", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Taken branch: delay set for one fetch only.
    fc_if.br_taken = 1'b1;
    chk_out("br", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    clr_in();
    chk_out("br+1", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk_out("br+2", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Priority among control transfers.
    fc_if.br_taken = 1'b1;
    fc_if.jr       = 1'b1;
    chk_out("br_jr", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    clr_in();
    fc_if.jump = 1'b1;
    fc_if.jr   = 1'b1;
    chk_out("j_jr", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    clr_in();
    fc_if.jr = 1'b1;
    chk_out("jr", 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();

    // Three stall cycles with jump pending; delay (1 from jr) must be held.
    clr_in();
    fc_if.stall_req = 1'b1;
    fc_if.jump      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_out("stall", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      step();
    end
    fc_if.stall_req = 1'b0;
    chk_out("stall_rel", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef IF_CTRL_STALL_CNT_EN
    check("stall_cnt3", 32'(fc_if.stall_cnt), 32'd3);
`endif
    step();
    clr_in();
    // md_busy stalls too, overriding a taken branch.
    fc_if.md_busy  = 1'b1;
    fc_if.br_taken = 1'b1;
    chk_out("md_busy", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    clr_in();
`ifdef IF_CTRL_STALL_CNT_EN
    check("stall_cnt4", 32'(fc_if.stall_cnt), 32'd4);
`endif

    // Exception entry, EXC_BUBBLES=2; int_req beats stall and is ignored in EXC.
    fc_if.int_req   = 1'b1;
    fc_if.stall_req = 1'b1;
    chk_out("exc_n", 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    fc_if.stall_req = 1'b0;
    chk_out("exc_n1", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("exc_n2", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    clr_in();
    chk_out("exc_n3", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // eret clears a pending delay flag and outranks a branch.
    fc_if.jump = 1'b1;
    step();
    clr_in();
    fc_if.eret     = 1'b1;
    fc_if.br_taken = 1'b1;
    chk_out("eret", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    clr_in();
    chk_out("eret+1", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("eret+2", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // int_req in the ERET cycle enters EXC.
    fc_if.eret = 1'b1;
    step();
    clr_in();
    fc_if.int_req = 1'b1;
    chk_out("eret_int", 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    clr_in();
    chk_out("eret_exc", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-EXC.
    Reset = 1'b0;
    chk_out("rst_exc", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef IF_CTRL_STALL_CNT_EN
    check("rst_exc.stall_cnt", 32'(fc_if.stall_cnt), 32'd0);
`endif
    @(negedge Clk);
    Reset = 1'b1;
    step();
    chk_out("post_rst", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    fc_if.jr = 1'b1;
    chk_out("post_rst_jr", 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    clr_in();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
